// File: rtl/vm2002_stock_arb_if.sv
// Shared types and the requester/table bundle for the vm2002 stock arbiter.
// status_t is the result code returned to the user side.
// Optional build macro VM2002_ARB_USER_PRI_EN (fixed user priority) affects
// only the arbiter itself; this bundle is identical in both builds.

package vm2002_stock_arb_pkg;
    typedef enum logic [1:0] {
        AVAILABLE    = 2'd0,
        OUT_OF_STOCK = 2'd1,
        ERROR        = 2'd2
    } status_t;
endpackage

// Handshake: a requester raises req with a stable payload and keeps it high
// until its done pulse; gnt is a one-cycle pulse when the arbiter latches the
// payload, done is a one-cycle pulse when results are valid; req must be low
// by the cycle after done, otherwise it is taken as a new request.
interface vm2002_stock_arb_if #(
    parameter int ITEM_W  = 3,
    parameter int COUNT_W = 4,
    parameter int COST_W  = 8
) ();
    import vm2002_stock_arb_pkg::*;

    // Supplier (restock) side
    logic                      sup_req;
    logic [ITEM_W-1:0]         sup_item;
    logic [COUNT_W-1:0]        sup_count;
    logic [COST_W-1:0]         sup_cost;
    logic                      sup_gnt;
    logic                      sup_done;
    logic                      sup_ovf;

    // User (query/dispense) side
    logic                      usr_req;
    logic [ITEM_W-1:0]         usr_item;
    logic                      usr_dispense;
    logic                      usr_gnt;
    logic                      usr_done;
    status_t                   usr_status;
    logic [COST_W-1:0]         usr_cost;

    // Arbiter state and stock table port ({cost, count} per entry)
    logic                      busy;
    logic                      tbl_rd_en;
    logic                      tbl_wr_en;
    logic [ITEM_W-1:0]         tbl_addr;
    logic [COST_W+COUNT_W-1:0] tbl_wdata;
    logic [COST_W+COUNT_W-1:0] tbl_rdata;

    // Environment side: both requesters plus the table memory
    modport master (
        output sup_req, sup_item, sup_count, sup_cost,
        input  sup_gnt, sup_done, sup_ovf,
        output usr_req, usr_item, usr_dispense,
        input  usr_gnt, usr_done, usr_status, usr_cost,
        input  busy, tbl_rd_en, tbl_wr_en, tbl_addr, tbl_wdata,
        output tbl_rdata
    );

    // Arbiter side
    modport slave (
        input  sup_req, sup_item, sup_count, sup_cost,
        output sup_gnt, sup_done, sup_ovf,
        input  usr_req, usr_item, usr_dispense,
        output usr_gnt, usr_done, usr_status, usr_cost,
        output busy, tbl_rd_en, tbl_wr_en, tbl_addr, tbl_wdata,
        input  tbl_rdata
    );
endinterface

// File: rtl/vm2002_stock_arb.sv
// vm2002 stock table arbiter: serialises supplier restocks and user
// queries/dispenses into read-modify-write cycles on a sync-read table.
// Sequence per op: IDLE -> RD -> WR -> RSP -> IDLE; item 0 skips to RSP.
// Build macro VM2002_ARB_USER_PRI_EN: user always wins a tie (no round-robin).

module vm2002_stock_arb
    import vm2002_stock_arb_pkg::*;
#(
    parameter int ITEM_W  = 3,
    parameter int COUNT_W = 4,
    parameter int COST_W  = 8
) (
    input  logic              clk,
    input  logic              hrst_n,
    vm2002_stock_arb_if.slave bus,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    // Latched operation
    logic                      r_usr;          // 1 = user op, 0 = supplier op
    logic [ITEM_W-1:0]         r_item;
    logic [COUNT_W-1:0]        r_sup_count;
    logic [COST_W-1:0]         r_sup_cost;
    logic                      r_usr_disp;

    // Held results
    status_t                   r_usr_status;
    logic [COST_W-1:0]         r_usr_cost;
    logic                      r_ovf;

    // Arbitration
    logic                      w_any_req;
    logic                      w_pick_usr;
    logic [ITEM_W-1:0]         w_item_in;
    logic                      w_item_valid;
    logic                      w_accept;

    // Modify datapath
    logic [COUNT_W-1:0]        w_old_count;
    logic [COST_W-1:0]         w_old_cost;
    logic [COUNT_W:0]          w_sum;
    logic [COUNT_W-1:0]        w_new_count;
    status_t                   w_res_status;
    logic                      w_mod_en;
    logic [COST_W+COUNT_W-1:0] w_mod_data;

    // FSM outputs
    logic                      w_sup_gnt;
    logic                      w_usr_gnt;
    logic                      w_sup_done;
    logic                      w_usr_done;
    logic                      w_rd_en;
    logic                      w_wr_en;
    logic [COST_W+COUNT_W-1:0] w_wdata;

    assign w_any_req    = bus.usr_req | bus.sup_req;

`ifdef VM2002_ARB_USER_PRI_EN
    assign w_pick_usr   = bus.usr_req;
`else
    // 1 = last grant went to the user; reset value lets the user win the first tie
    logic                      r_last_usr;

    assign w_pick_usr   = bus.usr_req & (~bus.sup_req | ~r_last_usr);

    // Round-robin pointer follows every grant
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n)       r_last_usr <= 1'b0;
        else if (w_accept) r_last_usr <= w_pick_usr;
    end
`endif

    assign w_item_in    = w_pick_usr ? bus.usr_item : bus.sup_item;
    assign w_item_valid = (w_item_in != '0);
    assign w_accept     = (r_state == S_IDLE) && w_any_req;

    // State register
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Capture the winning request's payload; later input changes are ignored
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_usr       <= 1'b0;
            r_item      <= '0;
            r_sup_count <= '0;
            r_sup_cost  <= '0;
            r_usr_disp  <= 1'b0;
        end else if (w_accept) begin
            r_usr       <= w_pick_usr;
            r_item      <= w_item_in;
            r_sup_count <= bus.sup_count;
            r_sup_cost  <= bus.sup_cost;
            r_usr_disp  <= bus.usr_dispense;
        end
    end

    // Compute the modified entry and result from the table read data
    always_comb begin
        w_old_count  = bus.tbl_rdata[COUNT_W-1:0];
        w_old_cost   = bus.tbl_rdata[COUNT_W +: COST_W];
        w_sum        = {1'b0, w_old_count} + {1'b0, r_sup_count};
        w_new_count  = w_sum[COUNT_W] ? '1 : w_sum[COUNT_W-1:0];
        w_res_status = AVAILABLE;
        w_mod_en     = 1'b0;
        w_mod_data   = '0;
        if (r_usr) begin
            if (w_old_count == '0) begin
                w_res_status = OUT_OF_STOCK;
            end else begin
                w_mod_en   = r_usr_disp;
                w_mod_data = {w_old_cost, w_old_count - COUNT_W'(1)};
            end
        end else begin
            // Restock always rewrites the entry with the new cost
            w_mod_en   = 1'b1;
            w_mod_data = {r_sup_cost, w_new_count};
        end
    end

    // Update held results so they are visible in the RSP (done) cycle
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            r_usr_status <= ERROR;
            r_usr_cost   <= '0;
            r_ovf        <= 1'b0;
        end else if (w_accept && !w_item_valid) begin
            if (w_pick_usr) begin
                r_usr_status <= ERROR;
                r_usr_cost   <= '0;
            end else begin
                r_ovf        <= 1'b0;
            end
        end else if (r_state == S_WR) begin
            if (r_usr) begin
                r_usr_status <= w_res_status;
                r_usr_cost   <= w_old_cost;
            end else begin
                r_ovf        <= w_sum[COUNT_W];
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_sup_gnt   = 1'b0;
        w_usr_gnt   = 1'b0;
        w_sup_done  = 1'b0;
        w_usr_done  = 1'b0;
        w_rd_en     = 1'b0;
        w_wr_en     = 1'b0;
        w_wdata     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_state_nxt = w_item_valid ? S_RD : S_RSP;
            end
            S_RD: begin
                w_sup_gnt   = ~r_usr;
                w_usr_gnt   = r_usr;
                w_rd_en     = 1'b1;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                w_wr_en     = w_mod_en;
                if (w_mod_en) w_wdata = w_mod_data;
                w_state_nxt = S_RSP;
            end
            S_RSP: begin
                w_sup_done  = ~r_usr;
                w_usr_done  = r_usr;
                // Invalid item never passed through RD, so grant here with done
                if (r_item == '0) begin
                    w_sup_gnt = ~r_usr;
                    w_usr_gnt = r_usr;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.sup_gnt    = w_sup_gnt;
    assign bus.usr_gnt    = w_usr_gnt;
    assign bus.sup_done   = w_sup_done;
    assign bus.usr_done   = w_usr_done;
    assign bus.sup_ovf    = w_sup_done & r_ovf;
    assign bus.usr_status = r_usr_status;
    assign bus.usr_cost   = r_usr_cost;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.tbl_rd_en  = w_rd_en;
    assign bus.tbl_wr_en  = w_wr_en;
    assign bus.tbl_addr   = r_item;
    assign bus.tbl_wdata  = w_wdata;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_vm2002_stock_arb.sv
// Self-checking bench for vm2002_stock_arb: directed sequence, table memory
// model, reference stock model and per-side result queues.

module tb_vm2002_stock_arb;
    import vm2002_stock_arb_pkg::*;

    localparam int ITEM_W  = 3;
    localparam int COUNT_W = 4;
    localparam int COST_W  = 8;
    localparam int W       = 2 + COST_W;   // {status, cost}

    logic clk = 1'b0;
    logic hrst_n;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic         ovf_q[$];

    logic [COST_W+COUNT_W-1:0] mem[8] = '{default: '0};
    int                        ref_cnt[8]  = '{default: 0};
    logic [COST_W-1:0]         ref_cost[8] = '{default: '0};

`ifdef VM2002_ARB_USER_PRI_EN
    bit exp_side[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    bit exp_side[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif

    vm2002_stock_arb_if #(.ITEM_W(ITEM_W), .COUNT_W(COUNT_W), .COST_W(COST_W)) bus ();

    vm2002_stock_arb #(.ITEM_W(ITEM_W), .COUNT_W(COUNT_W), .COST_W(COST_W)) dut (
        .clk         (clk),
        .hrst_n      (hrst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Sync-read stock table
    always @(posedge clk) begin
        if (bus.tbl_wr_en) mem[bus.tbl_addr] <= bus.tbl_wdata;
        if (bus.tbl_rd_en) bus.tbl_rdata <= mem[bus.tbl_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop the expected result whenever a side reports done
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic         eo;
        if (bus.usr_done) begin
            chk("usr_done_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("usr_result", {bus.usr_status, bus.usr_cost}, e);
            end
        end
        if (bus.sup_done) begin
            chk("sup_done_expected", 32'(ovf_q.size() != 0), 1);
            if (ovf_q.size() != 0) begin
                eo = ovf_q.pop_front();
                chk("sup_ovf", bus.sup_ovf, eo);
            end
        end
    end

    // Reference model for a user op; returns the expected table write
    task automatic push_usr(input logic [2:0] item, input bit disp,
                            output bit wr, output logic [11:0] wd, output logic [W-1:0] res);
        wr = 1'b0;
        wd = '0;
        if (item == 3'd0) begin
            res = {ERROR, 8'h00};
        end else if (ref_cnt[item] == 0) begin
            res = {OUT_OF_STOCK, ref_cost[item]};
        end else begin
            res = {AVAILABLE, ref_cost[item]};
            if (disp) begin
                ref_cnt[item] = ref_cnt[item] - 1;
                wr = 1'b1;
                wd = {ref_cost[item], 4'(ref_cnt[item])};
            end
        end
        exp_q.push_back(res);
    endtask

    // Reference model for a supplier op
    task automatic push_sup(input logic [2:0] item, input logic [3:0] cnt, input logic [7:0] cost,
                            output bit wr, output logic [11:0] wd);
        int  sum;
        bit  ovf;
        wr  = 1'b0;
        wd  = '0;
        ovf = 1'b0;
        if (item != 3'd0) begin
            sum = ref_cnt[item] + int'(cnt);
            ovf = (sum > 15);
            ref_cnt[item]  = ovf ? 15 : sum;
            ref_cost[item] = cost;
            wr = 1'b1;
            wd = {cost, 4'(ref_cnt[item])};
        end
        ovf_q.push_back(ovf);
    endtask

    task automatic wait_for(input int which, input string tag);
        bit hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk);
            case (which)
                0:       hit = bus.sup_gnt;
                1:       hit = bus.usr_gnt;
                2:       hit = bus.sup_done;
                3:       hit = bus.usr_done;
                default: hit = bus.sup_gnt | bus.usr_gnt;
            endcase
        end
        chk({tag, "_seen"}, 32'(hit), 1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_sup_gnt"},   bus.sup_gnt, 0);
        chk({p, "_sup_done"},  bus.sup_done, 0);
        chk({p, "_sup_ovf"},   bus.sup_ovf, 0);
        chk({p, "_usr_gnt"},   bus.usr_gnt, 0);
        chk({p, "_usr_done"},  bus.usr_done, 0);
        chk({p, "_usr_status"}, bus.usr_status, ERROR);
        chk({p, "_usr_cost"},  bus.usr_cost, 0);
        chk({p, "_busy"},      bus.busy, 0);
        chk({p, "_rd_en"},     bus.tbl_rd_en, 0);
        chk({p, "_wr_en"},     bus.tbl_wr_en, 0);
        chk({p, "_addr"},      bus.tbl_addr, 0);
        chk({p, "_wdata"},     bus.tbl_wdata, 0);
        chk({p, "_state"},     dbg_state, 0);
    endtask

    // One isolated op with cycle-exact checks of gnt/read/write/done
    task automatic op_timed(input bit is_usr, input logic [2:0] item, input logic [3:0] cnt,
                            input logic [7:0] cost, input bit disp, input string tag);
        bit           wr;
        logic [11:0]  wd;
        logic [W-1:0] res;
        res = '0;
        if (is_usr) push_usr(item, disp, wr, wd, res);
        else        push_sup(item, cnt, cost, wr, wd);
        @(negedge clk);
        if (is_usr) begin
            bus.usr_item = item; bus.usr_dispense = disp; bus.usr_req = 1'b1;
        end else begin
            bus.sup_item = item; bus.sup_count = cnt; bus.sup_cost = cost; bus.sup_req = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_gnt"},       is_usr ? bus.usr_gnt : bus.sup_gnt, 1);
        chk({tag, "_other_gnt"}, is_usr ? bus.sup_gnt : bus.usr_gnt, 0);
        if (item == 3'd0) begin
            chk({tag, "_done_with_gnt"}, is_usr ? bus.usr_done : bus.sup_done, 1);
            chk({tag, "_no_rd"}, bus.tbl_rd_en, 0);
        end else begin
            chk({tag, "_rd_en"}, bus.tbl_rd_en, 1);
            chk({tag, "_addr"},  bus.tbl_addr, item);
            // Payload changes after the grant must not affect the op
            bus.usr_item     = 3'($urandom_range(1, 7));
            bus.usr_dispense = ~disp;
            bus.sup_item     = 3'($urandom_range(1, 7));
            bus.sup_count    = 4'($urandom_range(0, 15));
            bus.sup_cost     = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk({tag, "_wr_en"}, bus.tbl_wr_en, wr);
            if (wr) chk({tag, "_wdata"}, bus.tbl_wdata, wd);
            chk({tag, "_gnt_pulse"}, is_usr ? bus.usr_gnt : bus.sup_gnt, 0);
            @(negedge clk);
            chk({tag, "_done"}, is_usr ? bus.usr_done : bus.sup_done, 1);
        end
        if (is_usr) bus.usr_req = 1'b0;
        else        bus.sup_req = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, bus.busy, 0);
        if (is_usr) chk({tag, "_held"}, {bus.usr_status, bus.usr_cost}, res);
    endtask

    initial begin
        bit           side;
        bit           d_wr;
        logic [11:0]  d_wd;
        logic [W-1:0] d_res;

        // Reset
        hrst_n = 1'b0;
        bus.sup_req = 1'b0; bus.sup_item = '0; bus.sup_count = '0; bus.sup_cost = '0;
        bus.usr_req = 1'b0; bus.usr_item = '0; bus.usr_dispense = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        hrst_n = 1'b1;
        @(negedge clk);
        chk_reset("por_rel");

        // Restock and query item 3
        op_timed(1'b0, 3'd3, 4'd5, 8'd25, 1'b0, "sup3_a");
        op_timed(1'b0, 3'd3, 4'd7, 8'd25, 1'b0, "sup3_b");
        op_timed(1'b0, 3'd3, 4'd9, 8'd25, 1'b0, "sup3_sat");
        op_timed(1'b1, 3'd3, 4'd0, 8'd0,  1'b0, "usr3_query");

        // Dispense down to empty, then invalid item from both sides
        op_timed(1'b0, 3'd5, 4'd1, 8'd40, 1'b0, "sup5");
        op_timed(1'b1, 3'd5, 4'd0, 8'd0,  1'b1, "usr5_disp");
        op_timed(1'b1, 3'd5, 4'd0, 8'd0,  1'b1, "usr5_empty");
        op_timed(1'b1, 3'd0, 4'd0, 8'd0,  1'b1, "usr_inv");
        op_timed(1'b0, 3'd0, 4'd3, 8'd11, 1'b0, "sup_inv");

        // Four ties in a row: last grant was the supplier
        @(negedge clk);
        bus.usr_item = 3'd3; bus.usr_dispense = 1'b0; bus.usr_req = 1'b1;
        push_usr(3'd3, 1'b0, d_wr, d_wd, d_res);
        bus.sup_item = 3'd7; bus.sup_count = 4'd1; bus.sup_cost = 8'd9; bus.sup_req = 1'b1;
        push_sup(3'd7, 4'd1, 8'd9, d_wr, d_wd);
        for (int r = 0; r < 4; r++) begin
            wait_for(4, $sformatf("tie%0d_gnt", r));
            side = bus.usr_gnt;
            chk($sformatf("tie%0d_side", r), 32'(side), 32'(exp_side[r]));
            wait_for(side ? 3 : 2, $sformatf("tie%0d_done", r));
            if (side) bus.usr_req = 1'b0;
            else      bus.sup_req = 1'b0;
            if (r < 3) begin
                @(negedge clk);
                if (side) begin
                    bus.usr_req = 1'b1;
                    push_usr(3'd3, 1'b0, d_wr, d_wd, d_res);
                end else begin
                    bus.sup_req = 1'b1;
                    push_sup(3'd7, 4'd1, 8'd9, d_wr, d_wd);
                end
            end
        end
        if (bus.usr_req) begin
            wait_for(3, "tie_tail_usr");
            bus.usr_req = 1'b0;
        end else if (bus.sup_req) begin
            wait_for(2, "tie_tail_sup");
            bus.sup_req = 1'b0;
        end
        @(negedge clk);
        chk("item7_count", mem[7], {ref_cost[7], 4'(ref_cnt[7])});

        // Same-item race on empty item 6: user served first
        op_timed(1'b0, 3'd0, 4'd1, 8'd1, 1'b0, "sup_inv2");
        @(negedge clk);
        bus.usr_item = 3'd6; bus.usr_dispense = 1'b1; bus.usr_req = 1'b1;
        push_usr(3'd6, 1'b1, d_wr, d_wd, d_res);
        bus.sup_item = 3'd6; bus.sup_count = 4'd2; bus.sup_cost = 8'd60; bus.sup_req = 1'b1;
        push_sup(3'd6, 4'd2, 8'd60, d_wr, d_wd);
        wait_for(4, "race_gnt");
        chk("race_usr_first", bus.usr_gnt, 1);
        wait_for(3, "race_usr_done");
        bus.usr_req = 1'b0;
        wait_for(2, "race_sup_done");
        bus.sup_req = 1'b0;
        @(negedge clk);
        chk("race_mem6", mem[6], {ref_cost[6], 4'(ref_cnt[6])});
        op_timed(1'b1, 3'd6, 4'd0, 8'd0, 1'b0, "race_query");

        // Reset in the middle of a write
        @(negedge clk);
        bus.sup_item = 3'd4; bus.sup_count = 4'd3; bus.sup_cost = 8'd77; bus.sup_req = 1'b1;
        @(negedge clk);
        chk("rst_op_gnt", bus.sup_gnt, 1);
        @(negedge clk);
        chk("rst_op_wr_before", bus.tbl_wr_en, 1);
        hrst_n = 1'b0;
        #1;
        chk("rst_wr_drop", bus.tbl_wr_en, 0);
        chk("rst_busy_drop", bus.busy, 0);
        bus.sup_req = 1'b0;
        @(negedge clk);
        chk_reset("mid_rst");
        hrst_n = 1'b1;
        @(negedge clk);
        chk_reset("mid_rel");
        chk("rst_no_write", mem[4], 0);

        // After reset the user wins the first tie
        bus.usr_item = 3'd0; bus.usr_req = 1'b1;
        push_usr(3'd0, 1'b0, d_wr, d_wd, d_res);
        bus.sup_item = 3'd0; bus.sup_req = 1'b1;
        push_sup(3'd0, 4'd0, 8'd0, d_wr, d_wd);
        wait_for(4, "rst_tie_gnt");
        chk("rst_tie_usr_first", bus.usr_gnt, 1);
        chk("rst_tie_usr_done", bus.usr_done, 1);
        bus.usr_req = 1'b0;
        wait_for(2, "rst_tie_sup_done");
        bus.sup_req = 1'b0;

        repeat (2) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("ovf_q_drained", ovf_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
